sal_sched: RTL and testbench

Channel-level command scheduler at the far end of the scheduling interface: it receives ACT/RD/WR/PRE/REF requests from `NUM_BANKS` bank controllers and grants at most one per cycle. It enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW) and registers the winning command onto the DRAM command path. It sits between the bank-controller array and the DDR2 command/address driver.

---
 rtl/sal_sched_if.sv | 48 ++++
 rtl/sal_sched.sv | 218 +++++++++++++++++++++
 tb/tb_sal_sched.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sal_sched_if.sv
// Scheduling interface between the bank-controller array (master) and the channel scheduler (slave).
// Carries per-bank requests and fields in, grants and the registered DRAM command out.
interface sal_sched_if #(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = 2,
    parameter int RA_W      = 14,
    parameter int CA_W      = 10,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 2
);
    logic [NUM_BANKS-1:0]       act_req_i;
    logic [NUM_BANKS-1:0]       rd_req_i;
    logic [NUM_BANKS-1:0]       wr_req_i;
    logic [NUM_BANKS-1:0]       pre_req_i;
    logic [NUM_BANKS-1:0]       ref_req_i;
    logic [NUM_BANKS*RA_W-1:0]  ra_i;
    logic [NUM_BANKS*CA_W-1:0]  ca_i;
    logic [NUM_BANKS*ID_W-1:0]  id_i;
    logic [NUM_BANKS*LEN_W-1:0] len_i;

    logic [NUM_BANKS-1:0]       act_gnt_o;
    logic [NUM_BANKS-1:0]       rd_gnt_o;
    logic [NUM_BANKS-1:0]       wr_gnt_o;
    logic [NUM_BANKS-1:0]       pre_gnt_o;
    logic [NUM_BANKS-1:0]       ref_gnt_o;

    logic                       cmd_valid_o;
    logic [2:0]                 cmd_o;
    logic [BA_W-1:0]            cmd_ba_o;
    logic [RA_W-1:0]            cmd_ra_o;
    logic [CA_W-1:0]            cmd_ca_o;
    logic [ID_W-1:0]            cmd_id_o;
    logic [LEN_W-1:0]           cmd_len_o;

    modport master (
        output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i,
        output ra_i, ca_i, id_i, len_i,
        input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
        input  cmd_valid_o, cmd_o, cmd_ba_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o
    );

    modport slave (
        input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i,
        input  ra_i, ca_i, id_i, len_i,
        output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
        output cmd_valid_o, cmd_o, cmd_ba_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o
    );
endinterface

// File: rtl/sal_sched.sv
// sal_sched: channel command scheduler, REF > CAS > PRE > ACT with one shared round-robin pointer; `SAL_SCHED_TIMING_CHECK_EN` adds tRRD/tCCD/tWTR/tRTW gating.
// Latency: grants are combinational in the request cycle; the winning command is registered onto cmd_* one cycle later.
// Backpressure: banks hold requests until granted; ineligible or outranked requests just see no grant, nothing is queued.
module sal_sched #(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = 2,
    parameter int RA_W      = 14,
    parameter int CA_W      = 10,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 2,
    parameter int T_RRD     = 2,
    parameter int T_CCD     = 2,
    parameter int T_WTR     = 3,
    parameter int T_RTW     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sal_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef struct packed {
        logic [RA_W-1:0]  ra;
        logic [CA_W-1:0]  ca;
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
    } fld_t;

    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 || BA_W != $clog2(NUM_BANKS)) begin : g_bad_banks
        $error("sal_sched: NUM_BANKS must be a power of two >= 2 with BA_W = log2(NUM_BANKS)");
    end
    if (T_RRD < 1 || T_RRD > 15 || T_CCD < 1 || T_CCD > 15 ||
        T_WTR < 1 || T_WTR > 15 || T_RTW < 1 || T_RTW > 15) begin : g_bad_timing
        $error("sal_sched: timing parameters must lie in 1..15");
    end

    cmd_e                 bank_cmd [NUM_BANKS];
    fld_t                 bank_fld [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_elig;
    logic [NUM_BANKS-1:0] ref_m, cas_m, pre_m, act_m, cls_m;

    logic                 rrd_ok, ccd_ok, wtr_ok, rtw_ok;

    logic                 gnt_vld;
    logic [BA_W-1:0]      gnt_ba;
    logic [BA_W-1:0]      rr_idx;
    cmd_e                 gnt_cmd;
    fld_t                 gnt_fld;
    logic [BA_W-1:0]      rr_ptr;

    logic [NUM_BANKS-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;

    logic                 cmd_vld_q;
    cmd_e                 cmd_q;
    logic [BA_W-1:0]      cmd_ba_q;
    fld_t                 cmd_fld_q;

    // Each bank presents only its highest-class request; eligibility is judged on that one alone.
    always_comb begin
        bank_elig = '0;
        ref_m     = '0;
        cas_m     = '0;
        pre_m     = '0;
        act_m     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_fld[b].ra  = bus.ra_i[b*RA_W +: RA_W];
            bank_fld[b].ca  = bus.ca_i[b*CA_W +: CA_W];
            bank_fld[b].id  = bus.id_i[b*ID_W +: ID_W];
            bank_fld[b].len = bus.len_i[b*LEN_W +: LEN_W];

            bank_cmd[b] = CMD_NOP;
            if (bus.ref_req_i[b])      bank_cmd[b] = CMD_REF;
            else if (bus.rd_req_i[b])  bank_cmd[b] = CMD_RD;
            else if (bus.wr_req_i[b])  bank_cmd[b] = CMD_WR;
            else if (bus.pre_req_i[b]) bank_cmd[b] = CMD_PRE;
            else if (bus.act_req_i[b]) bank_cmd[b] = CMD_ACT;

            case (bank_cmd[b])
                CMD_ACT:          bank_elig[b] = rrd_ok;
                CMD_RD:           bank_elig[b] = ccd_ok && wtr_ok;
                CMD_WR:           bank_elig[b] = ccd_ok && rtw_ok;
                CMD_PRE, CMD_REF: bank_elig[b] = 1'b1;
                default:          bank_elig[b] = 1'b0;
            endcase

            ref_m[b] = bank_elig[b] && (bank_cmd[b] == CMD_REF);
            cas_m[b] = bank_elig[b] && (bank_cmd[b] == CMD_RD || bank_cmd[b] == CMD_WR);
            pre_m[b] = bank_elig[b] && (bank_cmd[b] == CMD_PRE);
            act_m[b] = bank_elig[b] && (bank_cmd[b] == CMD_ACT);
        end
    end

    always_comb begin
        cls_m = act_m;
        if (|ref_m)      cls_m = ref_m;
        else if (|cas_m) cls_m = cas_m;
        else if (|pre_m) cls_m = pre_m;
    end

    // Round-robin scan of the winning class starting at rr_ptr; the BA_W-bit index wraps on its own.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ba  = '0;
        rr_idx  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            rr_idx = rr_ptr + k[BA_W-1:0];
            if (!gnt_vld && cls_m[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt_ba  = rr_idx;
            end
        end
        gnt_cmd = bank_cmd[gnt_ba];
        gnt_fld = bank_fld[gnt_ba];
    end

    always_comb begin
        act_gnt = '0;
        rd_gnt  = '0;
        wr_gnt  = '0;
        pre_gnt = '0;
        ref_gnt = '0;
        if (gnt_vld && rst_n) begin
            case (gnt_cmd)
                CMD_ACT: act_gnt[gnt_ba] = 1'b1;
                CMD_RD:  rd_gnt[gnt_ba]  = 1'b1;
                CMD_WR:  wr_gnt[gnt_ba]  = 1'b1;
                CMD_PRE: pre_gnt[gnt_ba] = 1'b1;
                CMD_REF: ref_gnt[gnt_ba] = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SAL_SCHED_TIMING_CHECK_EN
    localparam logic [3:0] RRD_LD = 4'(T_RRD - 1);
    localparam logic [3:0] CCD_LD = 4'(T_CCD - 1);
    localparam logic [3:0] WTR_LD = 4'(T_WTR - 1);
    localparam logic [3:0] RTW_LD = 4'(T_RTW - 1);

    logic [3:0] rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic       is_act, is_rd, is_wr;

    function automatic logic [3:0] dec_sat(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

    assign is_act = gnt_vld && (gnt_cmd == CMD_ACT);
    assign is_rd  = gnt_vld && (gnt_cmd == CMD_RD);
    assign is_wr  = gnt_vld && (gnt_cmd == CMD_WR);

    // Loading T-1 at the grant edge makes the dependent command eligible exactly T cycles after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt <= 4'd0;
            ccd_cnt <= 4'd0;
            wtr_cnt <= 4'd0;
            rtw_cnt <= 4'd0;
        end else begin
            rrd_cnt <= is_act           ? RRD_LD : dec_sat(rrd_cnt);
            ccd_cnt <= (is_rd || is_wr) ? CCD_LD : dec_sat(ccd_cnt);
            rtw_cnt <= is_rd            ? RTW_LD : dec_sat(rtw_cnt);
            wtr_cnt <= is_wr            ? WTR_LD : dec_sat(wtr_cnt);
        end
    end

    assign rrd_ok = (rrd_cnt == 4'd0);
    assign ccd_ok = (ccd_cnt == 4'd0);
    assign wtr_ok = (wtr_cnt == 4'd0);
    assign rtw_ok = (rtw_cnt == 4'd0);
`else
    assign rrd_ok = 1'b1;
    assign ccd_ok = 1'b1;
    assign wtr_ok = 1'b1;
    assign rtw_ok = 1'b1;
`endif

    // Fields hold on idle cycles so the address driver sees stable lines between commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld_q <= 1'b0;
            cmd_q     <= CMD_NOP;
            cmd_ba_q  <= '0;
            cmd_fld_q <= '0;
            rr_ptr    <= '0;
        end else if (gnt_vld) begin
            cmd_vld_q <= 1'b1;
            cmd_q     <= gnt_cmd;
            cmd_ba_q  <= gnt_ba;
            cmd_fld_q <= gnt_fld;
            rr_ptr    <= gnt_ba + 1'b1;
        end else begin
            cmd_vld_q <= 1'b0;
            cmd_q     <= CMD_NOP;
        end
    end

    assign bus.act_gnt_o   = act_gnt;
    assign bus.rd_gnt_o    = rd_gnt;
    assign bus.wr_gnt_o    = wr_gnt;
    assign bus.pre_gnt_o   = pre_gnt;
    assign bus.ref_gnt_o   = ref_gnt;
    assign bus.cmd_valid_o = cmd_vld_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.cmd_ba_o    = cmd_ba_q;
    assign bus.cmd_ra_o    = cmd_fld_q.ra;
    assign bus.cmd_ca_o    = cmd_fld_q.ca;
    assign bus.cmd_id_o    = cmd_fld_q.id;
    assign bus.cmd_len_o   = cmd_fld_q.len;

endmodule

// File: tb/tb_sal_sched.sv
// Bench for sal_sched: directed scenarios with literal expectations plus a cycle-accurate issue-time model.
// Expectations follow whether SAL_SCHED_TIMING_CHECK_EN is defined for the build.
module tb_sal_sched;
    localparam int NB    = 4;
    localparam int BA_W  = 2;
    localparam int RA_W  = 14;
    localparam int CA_W  = 10;
    localparam int ID_W  = 4;
    localparam int LEN_W = 2;
    localparam int T_RRD = 2;
    localparam int T_CCD = 2;
    localparam int T_WTR = 3;
    localparam int T_RTW = 4;
`ifdef SAL_SCHED_TIMING_CHECK_EN
    localparam bit TIMING = 1'b1;
`else
    localparam bit TIMING = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    sal_sched_if #(.NUM_BANKS(NB), .BA_W(BA_W), .RA_W(RA_W), .CA_W(CA_W),
                   .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    sal_sched #(.NUM_BANKS(NB), .BA_W(BA_W), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W),
                .LEN_W(LEN_W), .T_RRD(T_RRD), .T_CCD(T_CCD), .T_WTR(T_WTR),
                .T_RTW(T_RTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.act_req_i = '0;
        bus.rd_req_i  = '0;
        bus.wr_req_i  = '0;
        bus.pre_req_i = '0;
        bus.ref_req_i = '0;
        bus.ra_i      = '0;
        bus.ca_i      = '0;
        bus.id_i      = '0;
        bus.len_i     = '0;
    endtask

    task automatic set_fld(input int b, input int ra, input int ca, input int id, input int ln);
        bus.ra_i[b*RA_W +: RA_W]    = RA_W'(ra);
        bus.ca_i[b*CA_W +: CA_W]    = CA_W'(ca);
        bus.id_i[b*ID_W +: ID_W]    = ID_W'(id);
        bus.len_i[b*LEN_W +: LEN_W] = LEN_W'(ln);
    endtask

    // Returns at 1 ns after the posedge that opens scenario cycle 0, with reset just released.
    task automatic do_reset();
        start_cycle();
        rst_n = 1'b0;
        clear_inputs();
        start_cycle();
        start_cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- Reference model: tracks the cycle each command type last issued ----------------
    initial begin : model
        int t_cyc, l_act, l_cas, l_rd, l_wr, rr;
        int typ [NB];
        bit ok [NB];
        bit g_vld;
        int g_bank, g_typ, cls, b;
        logic [NB-1:0]    e_gnt [6];
        logic             e_vld;
        logic [2:0]       e_cmd;
        logic [BA_W-1:0]  e_ba;
        logic [RA_W-1:0]  e_ra, p_ra;
        logic [CA_W-1:0]  e_ca, p_ca;
        logic [ID_W-1:0]  e_id, p_id;
        logic [LEN_W-1:0] e_len, p_len;
        t_cyc = 0; l_act = -100; l_cas = -100; l_rd = -100; l_wr = -100; rr = 0;
        e_vld = 1'b0; e_cmd = 3'd0; e_ba = '0; e_ra = '0; e_ca = '0; e_id = '0; e_len = '0;
        p_ra = '0; p_ca = '0; p_id = '0; p_len = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 6; c++) e_gnt[c] = '0;
            g_vld = 1'b0; g_bank = 0; g_typ = 0;
            if (!rst_n) begin
                t_cyc = 0; l_act = -100; l_cas = -100; l_rd = -100; l_wr = -100; rr = 0;
                e_vld = 1'b0; e_cmd = 3'd0; e_ba = '0;
                e_ra = '0; e_ca = '0; e_id = '0; e_len = '0;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    typ[i] = bus.ref_req_i[i] ? 5 : bus.rd_req_i[i] ? 2 : bus.wr_req_i[i] ? 3 :
                             bus.pre_req_i[i] ? 4 : bus.act_req_i[i] ? 1 : 0;
                    case (typ[i])
                        1:       ok[i] = !TIMING || (t_cyc >= l_act + T_RRD);
                        2:       ok[i] = !TIMING || (t_cyc >= l_cas + T_CCD && t_cyc >= l_wr + T_WTR);
                        3:       ok[i] = !TIMING || (t_cyc >= l_cas + T_CCD && t_cyc >= l_rd + T_RTW);
                        4, 5:    ok[i] = 1'b1;
                        default: ok[i] = 1'b0;
                    endcase
                end
                // classes: 3=REF, 2=RD/WR, 1=PRE, 0=ACT
                for (int c = 3; c >= 0; c--) begin
                    for (int k = 0; k < NB; k++) begin
                        b = (rr + k) % NB;
                        cls = (typ[b] == 5) ? 3 : (typ[b] == 2 || typ[b] == 3) ? 2 : (typ[b] == 4) ? 1 : 0;
                        if (!g_vld && typ[b] != 0 && ok[b] && cls == c) begin
                            g_vld = 1'b1; g_bank = b; g_typ = typ[b];
                        end
                    end
                end
                if (g_vld) begin
                    e_gnt[g_typ][g_bank] = 1'b1;
                    p_ra  = bus.ra_i[g_bank*RA_W +: RA_W];
                    p_ca  = bus.ca_i[g_bank*CA_W +: CA_W];
                    p_id  = bus.id_i[g_bank*ID_W +: ID_W];
                    p_len = bus.len_i[g_bank*LEN_W +: LEN_W];
                end
            end
            chk("model_act_gnt", bus.act_gnt_o, e_gnt[1]);
            chk("model_rd_gnt",  bus.rd_gnt_o,  e_gnt[2]);
            chk("model_wr_gnt",  bus.wr_gnt_o,  e_gnt[3]);
            chk("model_pre_gnt", bus.pre_gnt_o, e_gnt[4]);
            chk("model_ref_gnt", bus.ref_gnt_o, e_gnt[5]);
            chk("model_cmd_valid", bus.cmd_valid_o, e_vld);
            chk("model_cmd",     bus.cmd_o,     e_cmd);
            chk("model_cmd_ba",  bus.cmd_ba_o,  e_ba);
            chk("model_cmd_ra",  bus.cmd_ra_o,  e_ra);
            chk("model_cmd_ca",  bus.cmd_ca_o,  e_ca);
            chk("model_cmd_id",  bus.cmd_id_o,  e_id);
            chk("model_cmd_len", bus.cmd_len_o, e_len);
            @(posedge clk);
            if (rst_n) begin
                if (g_vld) begin
                    e_vld = 1'b1; e_cmd = 3'(g_typ); e_ba = BA_W'(g_bank);
                    e_ra = p_ra; e_ca = p_ca; e_id = p_id; e_len = p_len;
                    rr = (g_bank + 1) % NB;
                    if (g_typ == 1) l_act = t_cyc;
                    if (g_typ == 2) begin l_cas = t_cyc; l_rd = t_cyc; end
                    if (g_typ == 3) begin l_cas = t_cyc; l_wr = t_cyc; end
                end else begin
                    e_vld = 1'b0; e_cmd = 3'd0;
                end
                t_cyc++;
            end
        end
    end

    // ---------------- Directed scenarios with hand-computed expectations ----------------
    int rr_gnt_on  [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    int rr_gnt_off [9] = '{1, 2, 4, 8, 1, 2, 4, 8, 1};
    int rr_vld_on  [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    int rr_vld_off [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    int rr_ba_on   [9] = '{0, 0, 0, 1, 0, 2, 0, 3, 0};
    int rr_ba_off  [9] = '{0, 0, 1, 2, 3, 0, 1, 2, 3};

    initial begin : stim
        int g1, drop, vld, ba;
        clear_inputs();
        start_cycle();
        start_cycle();
        chk("reset_cmd_valid", bus.cmd_valid_o, 1'b0);
        chk("reset_cmd", bus.cmd_o, 3'd0);
        chk("reset_cmd_ra", bus.cmd_ra_o, '0);

        // Round-robin over four banks all requesting RD.
        do_reset();
        for (int b = 0; b < NB; b++) set_fld(b, 16'h100 + b, 16'h40 + b, b + 1, b);
        for (int t = 0; t < 9; t++) begin
            if (t > 0) start_cycle();
            bus.rd_req_i = 4'hf;
            @(negedge clk);
            vld = TIMING ? rr_vld_on[t] : rr_vld_off[t];
            ba  = TIMING ? rr_ba_on[t]  : rr_ba_off[t];
            chk("rr_rd_gnt", bus.rd_gnt_o, TIMING ? rr_gnt_on[t] : rr_gnt_off[t]);
            chk("rr_cmd_valid", bus.cmd_valid_o, vld);
            chk("rr_cmd", bus.cmd_o, (vld != 0) ? 2 : 0);
            if (vld != 0) chk("rr_cmd_ba", bus.cmd_ba_o, ba);
        end

        // Asynchronous reset in the middle of RD traffic.
        do_reset();
        for (int b = 0; b < NB; b++) set_fld(b, 16'h200 + b, 16'h80 + b, b + 5, b);
        for (int t = 0; t < 4; t++) begin
            if (t > 0) start_cycle();
            bus.rd_req_i = 4'hf;
            @(negedge clk);
        end
        #2;
        chk("pre_reset_cmd_valid", bus.cmd_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_cmd_valid", bus.cmd_valid_o, 1'b0);
        chk("async_reset_cmd", bus.cmd_o, 3'd0);
        chk("async_reset_cmd_ba", bus.cmd_ba_o, '0);
        chk("async_reset_cmd_ra", bus.cmd_ra_o, '0);
        chk("async_reset_rd_gnt", bus.rd_gnt_o, '0);
        start_cycle();
        start_cycle();
        rst_n = 1'b1;
        bus.rd_req_i = 4'hf;
        @(negedge clk);
        chk("post_reset_first_gnt", bus.rd_gnt_o, 4'b0001);
        start_cycle();
        @(negedge clk);
        chk("post_reset_cmd", bus.cmd_o, 3'd2);
        chk("post_reset_cmd_ba", bus.cmd_ba_o, 2'd0);

        // Class priority: REF on bank 1 beats RD on bank 2.
        do_reset();
        set_fld(1, 16'h11, 16'h21, 3, 1);
        set_fld(2, 16'h12, 16'h22, 4, 2);
        bus.ref_req_i = 4'b0010;
        bus.rd_req_i  = 4'b0100;
        @(negedge clk);
        chk("prio_ref_gnt_c0", bus.ref_gnt_o, 4'b0010);
        chk("prio_rd_gnt_c0", bus.rd_gnt_o, 4'b0000);
        start_cycle();
        bus.ref_req_i = 4'b0000;
        @(negedge clk);
        chk("prio_rd_gnt_c1", bus.rd_gnt_o, 4'b0100);
        chk("prio_cmd_c1", bus.cmd_o, 3'd5);
        chk("prio_cmd_ba_c1", bus.cmd_ba_o, 2'd1);
        start_cycle();
        bus.rd_req_i = 4'b0000;
        @(negedge clk);
        chk("prio_cmd_c2", bus.cmd_o, 3'd2);
        chk("prio_cmd_ba_c2", bus.cmd_ba_o, 2'd2);
        chk("prio_cmd_ca_c2", bus.cmd_ca_o, 10'h22);

        // Write-to-read turnaround: WR bank 0, then RD bank 1.
        do_reset();
        g1   = TIMING ? 3 : 1;
        drop = g1 + 1;
        bus.wr_req_i = 4'b0001;
        @(negedge clk);
        chk("wtr_wr_gnt_c0", bus.wr_gnt_o, 4'b0001);
        for (int t = 1; t < 6; t++) begin
            start_cycle();
            bus.wr_req_i = 4'b0000;
            bus.rd_req_i = (t < drop) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            chk("wtr_rd_gnt", bus.rd_gnt_o, (t == g1) ? 4'b0010 : 4'b0000);
        end

        // ACT-to-ACT spacing on banks 0 and 1.
        do_reset();
        set_fld(0, 16'h10, 0, 0, 0);
        set_fld(1, 16'h20, 0, 0, 0);
        g1 = TIMING ? 2 : 1;
        for (int t = 0; t < 5; t++) begin
            if (t > 0) start_cycle();
            bus.act_req_i = (t == 0) ? 4'b0011 : (t <= g1) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            chk("rrd_act_gnt", bus.act_gnt_o, (t == 0) ? 4'b0001 : (t == g1) ? 4'b0010 : 4'b0000);
            if (t == 1) chk("rrd_cmd_ra_first", bus.cmd_ra_o, 14'h10);
            if (t == g1 + 1) chk("rrd_cmd_ra_second", bus.cmd_ra_o, 14'h20);
        end

        // Mixed traffic checked by the model alone.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n > 0) start_cycle();
            bus.act_req_i = 4'($urandom_range(0, 15));
            bus.rd_req_i  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.wr_req_i  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.pre_req_i = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.ref_req_i = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int b = 0; b < NB; b++)
                set_fld(b, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        end
        start_cycle();
        clear_inputs();
        start_cycle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end
endmodule
